// File: rtl/alu_bist_pkg.sv
// ---------------------------------------------------------------------------
// alu_bist_pkg
// Shared definitions for the ALU built-in self-test block:
//   - ALU operation encodings walked by the vector counter
//   - operand LFSR and signature MISR polynomials
//   - sequencer state encoding
//   - small helpers for zero-seed substitution and the MISR step
// No ports (package).
// ---------------------------------------------------------------------------
package alu_bist_pkg;

  // ALU operation encodings, matching the ALU's op input.
  typedef enum logic [2:0] {
    OP_ROL = 3'd0,
    OP_SLL = 3'd1,
    OP_ROR = 3'd2,
    OP_SRA = 3'd3,
    OP_ADD = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_AND = 3'd7
  } alu_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

  // Right-shifting Galois polynomial for the operand generators.
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // Left-shifting polynomial for the response compactor.
  localparam logic [15:0] MISR_POLY = 16'h1021;

  // An all-zero LFSR state never leaves zero, so it is replaced.
  localparam logic [15:0] ZERO_SEED_SUB = 16'h0001;

  // Seed actually loaded into an operand LFSR.
  function automatic logic [15:0] fixSeed(input logic [15:0] seed);
    return (seed == 16'h0000) ? ZERO_SEED_SUB : seed;
  endfunction

  // One MISR step: shift left with feedback, then fold in the data word.
  function automatic logic [15:0] misrNext(input logic [15:0] sig,
                                           input logic [15:0] data);
    return ({sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000)) ^ data;
  endfunction

endpackage

// File: rtl/alu_bist_if.sv
// ---------------------------------------------------------------------------
// alu_bist_if
// Bundle between the self-test sequencer and the combinational ALU.
//   a, b            : ALU operands            (driven by the BIST)
//   op              : ALU operation code      (driven by the BIST)
//   cin, invA, invB,
//   sign            : ALU control bits        (driven by the BIST)
//   out             : ALU result              (driven by the ALU)
//   ofl, zero       : ALU flags               (driven by the ALU)
// Modports: master = stimulus/checking side, slave = ALU side.
// ---------------------------------------------------------------------------
interface alu_bist_if;
  import alu_bist_pkg::*;

  logic [15:0] a;
  logic [15:0] b;
  alu_op_e     op;
  logic        cin;
  logic        invA;
  logic        invB;
  logic        sign;
  logic [15:0] out;
  logic        ofl;
  logic        zero;

  modport master (
    output a, b, op, cin, invA, invB, sign,
    input  out, ofl, zero
  );

  modport slave (
    input  a, b, op, cin, invA, invB, sign,
    output out, ofl, zero
  );

endinterface

// File: rtl/alu_bist_lfsr16.sv
// ---------------------------------------------------------------------------
// bist_lfsr16
// 16-bit right-shifting Galois LFSR used as an operand generator.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset, clears the state to 0
//   load_i  : load seed_i (with zero-seed substitution); wins over en_i
//   seed_i  : seed value
//   en_i    : advance one step
//   state_o : current LFSR state
// ---------------------------------------------------------------------------
module bist_lfsr16
  import alu_bist_pkg::*;
#(
  parameter logic [15:0] POLY = LFSR_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Load has priority so a run entry always starts from a known seed,
  // even if the sequencer were to request a step on the same edge.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = fixSeed(seed_i);
    end else if (en_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? POLY : 16'h0000);
    end
  end

  // Reset clears to 0 so the ALU operand bus reads 0 outside of a run;
  // the zero state is never stepped because every run loads a seed first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 16'h0000;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/alu_bist.sv
// ---------------------------------------------------------------------------
// alu_bist
// Built-in self-test sequencer for the 16-bit ALU. On start it drives one
// pseudo-random vector per cycle, compacts every ALU response into a 16-bit
// MISR signature and flags pass when the final signature equals GOLDEN_SIG.
// Ports:
//   clk         : clock
//   rst         : synchronous active-high reset
//   start_i     : begin a run (honoured only in IDLE or DONE)
//   busy_o      : high while running
//   done_o      : high once the run has finished, until restart or reset
//   pass_o      : valid while done_o; final signature matched GOLDEN_SIG
//   signature_o : MISR state
//   alu         : master side of the ALU bundle (operands, controls, result)
// ---------------------------------------------------------------------------
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned N_VECTORS  = 256,
  parameter logic [15:0] SEED_A     = 16'hACE1,
  parameter logic [15:0] SEED_B     = 16'h1D2B,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [15:0]   signature_o,
  alu_bist_if.master    alu
);

  localparam logic [15:0] LAST_CNT = 16'(N_VECTORS - 1);

  bist_state_e state_q;
  bist_state_e state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] sig_q;
  logic [15:0] sig_d;
  logic        pass_q;
  logic        pass_d;

  logic        runEntry;
  logic        lfsrEn;
  logic        lastVec;
  logic [15:0] misrData;
  logic [15:0] sigNext;
  logic [15:0] opA;
  logic [15:0] opB;

  // Operand generators: both reload on run entry and step once per
  // absorbed vector, except on the final vector so DONE keeps showing it.
  bist_lfsr16 #(
    .POLY (LFSR_POLY)
  ) uLfsrA (
    .clk     (clk),
    .rst     (rst),
    .load_i  (runEntry),
    .seed_i  (SEED_A),
    .en_i    (lfsrEn),
    .state_o (opA)
  );

  bist_lfsr16 #(
    .POLY (LFSR_POLY)
  ) uLfsrB (
    .clk     (clk),
    .rst     (rst),
    .load_i  (runEntry),
    .seed_i  (SEED_B),
    .en_i    (lfsrEn),
    .state_o (opB)
  );

  // State, counter, signature and pass flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'h0000;
      sig_q   <= 16'h0000;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic. In RUN every edge absorbs the vector currently on
  // the bus; the flags are folded into the two low bits of the data word.
  // pass is decided from the signature being written on the DONE edge,
  // so it is valid in the same cycle done rises.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sig_d    = sig_q;
    pass_d   = pass_q;
    runEntry = 1'b0;
    lfsrEn   = 1'b0;
    misrData = alu.out ^ {14'b0, alu.ofl, alu.zero};
    sigNext  = misrNext(sig_q, misrData);
    lastVec  = (cnt_q == LAST_CNT);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d  = ST_RUN;
          runEntry = 1'b1;
          cnt_d    = 16'h0000;
          sig_d    = 16'h0000;
          pass_d   = 1'b0;
        end
      end
      ST_RUN: begin
        sig_d = sigNext;
        if (lastVec) begin
          state_d = ST_DONE;
          pass_d  = (sigNext == GOLDEN_SIG);
        end else begin
          cnt_d  = cnt_q + 16'd1;
          lfsrEn = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control bits are a direct decode of the vector counter, so the low
  // 7 bits sweep every op under every inversion/carry/sign combination.
  assign alu.a    = opA;
  assign alu.b    = opB;
  assign alu.op   = alu_op_e'(cnt_q[2:0]);
  assign alu.invA = cnt_q[3];
  assign alu.invB = cnt_q[4];
  assign alu.cin  = cnt_q[5];
  assign alu.sign = cnt_q[6];

  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);
  assign pass_o      = pass_q;
  assign signature_o = sig_q;

endmodule

// File: tb/tb_alu_bist.sv
// ---------------------------------------------------------------------------
// tb_alu_bist
// Self-checking bench for alu_bist. Three sequencers are instantiated, each
// beside a behavioural ALU:
//   dutMain : default seeds, 8 vectors, ALU result XORed with a per-run key
//   dutOne  : 1 vector, golden signature set for the plain ALU
//   dutZero : operand-A seed 0, 130 vectors (exercises every control bit)
// ---------------------------------------------------------------------------
module tb_alu_bist;

  localparam int          N_MAIN    = 8;
  localparam int          N_ZERO    = 130;
  localparam logic [15:0] GOLD_MAIN = 16'h0000;
  localparam logic [15:0] GOLD_ONE  = 16'h0D67;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic startMain = 1'b0;
  logic startOne  = 1'b0;
  logic startZero = 1'b0;
  logic [15:0] keyMain = 16'h0000;
  logic stuckOne = 1'b0;

  int checks = 0;
  int errors = 0;

  logic busyMain, doneMain, passMain;
  logic busyOne, doneOne, passOne;
  logic busyZero, doneZero, passZero;
  logic [15:0] sigMain, sigOne, sigZero;

  logic [15:0] expA [256];
  logic [15:0] expB [256];

  alu_bist_if ifMain ();
  alu_bist_if ifOne ();
  alu_bist_if ifZero ();

  always #5 clk = ~clk;

  // Behavioural ALU: {out, ofl, zero}. Shifts use the low nibble of the
  // (possibly inverted) B operand; ofl is only meaningful for ADD.
  function automatic logic [17:0] aluRef(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [2:0]  op,
                                         input logic        cin,
                                         input logic        invA,
                                         input logic        invB,
                                         input logic        sign);
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] r;
    logic [31:0] dbl;
    logic [16:0] sum;
    logic        ofl;
    int          sh;
    x   = invA ? ~a : a;
    y   = invB ? ~b : b;
    sh  = int'(y[3:0]);
    dbl = {x, x};
    ofl = 1'b0;
    sum = 17'h0;
    case (op)
      3'd0: r = 16'((dbl << sh) >> 16);
      3'd1: r = x << sh;
      3'd2: r = 16'(dbl >> sh);
      3'd3: r = $signed(x) >>> sh;
      3'd4: begin
        sum = {1'b0, x} + {1'b0, y} + {16'b0, cin};
        r   = sum[15:0];
        ofl = sign ? ((x[15] == y[15]) && (r[15] != x[15])) : sum[16];
      end
      3'd5: r = x | y;
      3'd6: r = x ^ y;
      default: r = x & y;
    endcase
    return {r, ofl, (r == 16'h0000)};
  endfunction

  logic [17:0] respMain, respOne, respZero;
  assign respMain = aluRef(ifMain.a, ifMain.b, ifMain.op, ifMain.cin,
                           ifMain.invA, ifMain.invB, ifMain.sign);
  assign respOne  = aluRef(ifOne.a, ifOne.b, ifOne.op, ifOne.cin,
                           ifOne.invA, ifOne.invB, ifOne.sign);
  assign respZero = aluRef(ifZero.a, ifZero.b, ifZero.op, ifZero.cin,
                           ifZero.invA, ifZero.invB, ifZero.sign);

  assign ifMain.out  = respMain[17:2] ^ keyMain;
  assign ifMain.ofl  = respMain[1];
  assign ifMain.zero = respMain[0];
  assign ifOne.out   = respOne[17:2] & ~{15'b0, stuckOne};
  assign ifOne.ofl   = respOne[1];
  assign ifOne.zero  = respOne[0];
  assign ifZero.out  = respZero[17:2];
  assign ifZero.ofl  = respZero[1];
  assign ifZero.zero = respZero[0];

  alu_bist #(
    .N_VECTORS  (N_MAIN),
    .SEED_A     (16'hACE1),
    .SEED_B     (16'h1D2B),
    .GOLDEN_SIG (GOLD_MAIN)
  ) dutMain (
    .clk         (clk),
    .rst         (rst),
    .start_i     (startMain),
    .busy_o      (busyMain),
    .done_o      (doneMain),
    .pass_o      (passMain),
    .signature_o (sigMain),
    .alu         (ifMain)
  );

  alu_bist #(
    .N_VECTORS  (1),
    .SEED_A     (16'hACE1),
    .SEED_B     (16'h1D2B),
    .GOLDEN_SIG (GOLD_ONE)
  ) dutOne (
    .clk         (clk),
    .rst         (rst),
    .start_i     (startOne),
    .busy_o      (busyOne),
    .done_o      (doneOne),
    .pass_o      (passOne),
    .signature_o (sigOne),
    .alu         (ifOne)
  );

  alu_bist #(
    .N_VECTORS  (N_ZERO),
    .SEED_A     (16'h0000),
    .SEED_B     (16'h1D2B),
    .GOLDEN_SIG (16'h0000)
  ) dutZero (
    .clk         (clk),
    .rst         (rst),
    .start_i     (startZero),
    .busy_o      (busyZero),
    .done_o      (doneZero),
    .pass_o      (passZero),
    .signature_o (sigZero),
    .alu         (ifZero)
  );

  // Reference model of a complete run: vector list plus final signature,
  // computed straight from the LFSR/MISR rules and the counter decode.
  task automatic buildModel(input logic [15:0] sa, input logic [15:0] sb,
                            input int n, input logic [15:0] key,
                            output logic [15:0] sig);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic [17:0] r;
    a   = (sa == 16'h0) ? 16'h0001 : sa;
    b   = (sb == 16'h0) ? 16'h0001 : sb;
    sig = 16'h0000;
    for (int i = 0; i < n; i++) begin
      expA[i] = a;
      expB[i] = b;
      r = aluRef(a, b, 3'(i % 8), 1'((i / 32) % 2), 1'((i / 8) % 2),
                 1'((i / 16) % 2), 1'((i / 64) % 2));
      d = (r[17:2] ^ key) ^ {14'b0, r[1:0]};
      sig = ({sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000)) ^ d;
      a = (a >> 1) ^ (a[0] ? 16'hB400 : 16'h0000);
      b = (b >> 1) ^ (b[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  function automatic logic [3:0] ctrlOf(input int i);
    return {1'((i / 64) % 2), 1'((i / 32) % 2), 1'((i / 16) % 2), 1'((i / 8) % 2)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive main-DUT inputs, then sample just after the following edge.
  task automatic applyStimulus(input logic rstV, input logic startV);
    rst       = rstV;
    startMain = startV;
    @(posedge clk);
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZeroMain(input string tag);
    checkOutput({tag, " busy"}, 32'(busyMain), 32'd0);
    checkOutput({tag, " done"}, 32'(doneMain), 32'd0);
    checkOutput({tag, " pass"}, 32'(passMain), 32'd0);
    checkOutput({tag, " sig"}, 32'(sigMain), 32'd0);
    checkOutput({tag, " a"}, 32'(ifMain.a), 32'd0);
    checkOutput({tag, " b"}, 32'(ifMain.b), 32'd0);
    checkOutput({tag, " op"}, 32'(ifMain.op), 32'd0);
    checkOutput({tag, " ctrl"},
                32'({ifMain.sign, ifMain.cin, ifMain.invB, ifMain.invA}), 32'd0);
  endtask

  // Full main-DUT run with per-cycle checks; optional reset at abortAt.
  task automatic runMain(input logic [15:0] key, input logic holdStart,
                         input int abortAt, output logic endDone,
                         output logic [15:0] sigOut);
    logic [15:0] sigExp;
    keyMain = key;
    buildModel(16'hACE1, 16'h1D2B, N_MAIN, key, sigExp);
    sigOut  = sigExp;
    endDone = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("entry sig", 32'(sigMain), 32'd0);
    checkOutput("entry pass", 32'(passMain), 32'd0);
    for (int i = 0; i < N_MAIN; i++) begin
      checkOutput("run busy", 32'(busyMain), 32'd1);
      checkOutput("run done", 32'(doneMain), 32'd0);
      checkOutput("run a", 32'(ifMain.a), 32'(expA[i]));
      checkOutput("run b", 32'(ifMain.b), 32'(expB[i]));
      checkOutput("run op", 32'(ifMain.op), 32'(i % 8));
      checkOutput("run ctrl",
                  32'({ifMain.sign, ifMain.cin, ifMain.invB, ifMain.invA}),
                  32'(ctrlOf(i)));
      if (i == abortAt) begin
        applyStimulus(1'b1, holdStart);
        checkAllZeroMain("abort");
        return;
      end
      applyStimulus(1'b0, holdStart);
    end
    checkOutput("end busy", 32'(busyMain), 32'd0);
    checkOutput("end done", 32'(doneMain), 32'd1);
    checkOutput("end sig", 32'(sigMain), 32'(sigExp));
    checkOutput("end pass", 32'(passMain), 32'(sigExp == GOLD_MAIN));
    checkOutput("end a hold", 32'(ifMain.a), 32'(expA[N_MAIN - 1]));
    checkOutput("end op hold", 32'(ifMain.op), 32'((N_MAIN - 1) % 8));
    startMain = 1'b0;
    endDone   = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic        expBusy;
    logic        expDone;
    logic [15:0] expA;
    logic [15:0] expB;
    logic [2:0]  expOp;
    logic        chkSig;
    logic [15:0] expSig;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic        endDone;
    logic [15:0] sigRef;
    logic [15:0] sigTmp;
    logic [15:0] sigZ;
    int          abortAt;
    int          gap;
    logic        hold;

    vecs[0] = '{"rst+start",   1, 1, 0, 0, 16'h0000, 16'h0000, 3'd0, 1, 16'h0000};
    vecs[1] = '{"rst hold",    1, 1, 0, 0, 16'h0000, 16'h0000, 3'd0, 1, 16'h0000};
    vecs[2] = '{"start edge",  0, 1, 1, 0, 16'hACE1, 16'h1D2B, 3'd0, 1, 16'h0000};
    vecs[3] = '{"vec1",        0, 0, 1, 0, 16'hE270, 16'hBA95, 3'd1, 1, 16'h0D67};
    vecs[4] = '{"vec2",        0, 0, 1, 0, 16'h7138, 16'hE94A, 3'd2, 0, 16'h0000};
    vecs[5] = '{"rst midrun",  1, 0, 0, 0, 16'h0000, 16'h0000, 3'd0, 1, 16'h0000};
    vecs[6] = '{"rst+start 2", 1, 1, 0, 0, 16'h0000, 16'h0000, 3'd0, 1, 16'h0000};

    $display("[TB] table-driven reset/start sequence");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].start);
      checkOutput({vecs[i].name, " busy"}, 32'(busyMain), 32'(vecs[i].expBusy));
      checkOutput({vecs[i].name, " done"}, 32'(doneMain), 32'(vecs[i].expDone));
      checkOutput({vecs[i].name, " a"}, 32'(ifMain.a), 32'(vecs[i].expA));
      checkOutput({vecs[i].name, " b"}, 32'(ifMain.b), 32'(vecs[i].expB));
      checkOutput({vecs[i].name, " op"}, 32'(ifMain.op), 32'(vecs[i].expOp));
      if (vecs[i].chkSig) begin
        checkOutput({vecs[i].name, " sig"}, 32'(sigMain), 32'(vecs[i].expSig));
      end
      if (i == 1) begin
        checkAllZeroMain("reset");
      end
    end
    applyStimulus(1'b0, 1'b0);
    checkAllZeroMain("idle");

    $display("[TB] uninterrupted run, reset at vector 3, rerun");
    runMain(16'h0000, 1'b0, -1, endDone, sigRef);
    runMain(16'h0000, 1'b0, 3, endDone, sigTmp);
    runMain(16'h0000, 1'b0, -1, endDone, sigTmp);
    checkOutput("rerun sig", 32'(sigMain), 32'(sigRef));

    $display("[TB] start held through run, then restart from DONE");
    runMain(16'h5A5A, 1'b1, -1, endDone, sigTmp);
    runMain(16'h0000, 1'b0, -1, endDone, sigTmp);

    $display("[TB] randomized runs");
    for (int k = 0; k < 8; k++) begin
      hold    = 1'($urandom_range(0, 1));
      abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N_MAIN - 1)) : -1;
      runMain(16'($urandom), hold, abortAt, endDone, sigTmp);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, 1'b0);
        checkOutput("gap done", 32'(doneMain), 32'(endDone));
        checkOutput("gap busy", 32'(busyMain), 32'd0);
      end
    end

    $display("[TB] single-vector run with golden signature");
    startOne = 1'b1;
    stepCycle();
    checkOutput("one busy", 32'(busyOne), 32'd1);
    checkOutput("one a", 32'(ifOne.a), 32'hACE1);
    startOne = 1'b0;
    stepCycle();
    checkOutput("one done", 32'(doneOne), 32'd1);
    checkOutput("one busy end", 32'(busyOne), 32'd0);
    checkOutput("one sig", 32'(sigOne), 32'(GOLD_ONE));
    checkOutput("one pass", 32'(passOne), 32'd1);
    startOne = 1'b1;
    stepCycle();
    checkOutput("restart done", 32'(doneOne), 32'd0);
    checkOutput("restart pass", 32'(passOne), 32'd0);
    checkOutput("restart busy", 32'(busyOne), 32'd1);
    checkOutput("restart a", 32'(ifOne.a), 32'hACE1);
    startOne = 1'b0;
    stuckOne = 1'b1;
    stepCycle();
    stuckOne = 1'b0;
    checkOutput("stuck done", 32'(doneOne), 32'd1);
    checkOutput("stuck pass", 32'(passOne), 32'd0);
    checkOutput("stuck sig", 32'(sigOne), 32'h0D66);

    $display("[TB] zero seed and full control-bit sweep");
    buildModel(16'h0000, 16'h1D2B, N_ZERO, 16'h0000, sigZ);
    startZero = 1'b1;
    stepCycle();
    startZero = 1'b0;
    checkOutput("zero seed a0", 32'(ifZero.a), 32'h0001);
    stepCycle();
    checkOutput("zero seed a1", 32'(ifZero.a), 32'hB400);
    for (int i = 1; i < N_ZERO; i++) begin
      checkOutput("zero a", 32'(ifZero.a), 32'(expA[i]));
      checkOutput("zero b", 32'(ifZero.b), 32'(expB[i]));
      checkOutput("zero op", 32'(ifZero.op), 32'(i % 8));
      checkOutput("zero ctrl",
                  32'({ifZero.sign, ifZero.cin, ifZero.invB, ifZero.invA}),
                  32'(ctrlOf(i)));
      checkOutput("zero busy", 32'(busyZero), 32'd1);
      stepCycle();
    end
    checkOutput("zero done", 32'(doneZero), 32'd1);
    checkOutput("zero sig", 32'(sigZero), 32'(sigZ));
    checkOutput("zero pass", 32'(passZero), 32'(sigZ == 16'h0000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test sequencer for the 16-bit ALU. On `start` it drives the ALU's operand and control inputs with a pseudo-random vector stream, one vector per cycle. It compresses every ALU response (`out`, `ofl`, `zero`) into a 16-bit MISR signature and compares the final signature against a golden value. It sits beside the ALU in the execute stage and acts as the stimulus and checking end of the ALU interface for power-on or debug self-test.

## Interface
- `N_VECTORS`, 256: vectors per run; legal range 1..65535.
- `SEED_A`, 16'hACE1: initial operand-A LFSR state; a value of 0 is replaced by 16'h0001.
- `SEED_B`, 16'h1D2B: initial operand-B LFSR state; a value of 0 is replaced by 16'h0001.
- `GOLDEN_SIG`, 16'h0000: expected final signature, generated from the reference ALU model.
- `clk` in 1: the single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run. Sampled only in IDLE or DONE.
- `busy` out 1: high while in RUN.
- `done` out 1: high while in DONE.
- `pass` out 1: valid while `done`; 1 when `signature == GOLDEN_SIG`.
- `signature` out 16: MISR state.
- `alu_a`, `alu_b` out 16: ALU operands.
- `alu_op` out 3: ALU operation code.
- `alu_cin`, `alu_invA`, `alu_invB`, `alu_sign` out 1 each: ALU control bits.
- `alu_out` in 16: ALU result.
- `alu_ofl`, `alu_zero` in 1 each: ALU flags.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE + `start` → RUN.
  - RUN, after the last vector is absorbed → DONE.
  - DONE + `start` → RUN (restart).
  - Any state + `rst` → IDLE.
  - `start` is ignored in RUN.
- Run entry (edge where `start` is sampled):
  - Operand A LFSR loads `SEED_A`; operand B LFSR loads `SEED_B`, each with zero-seed substitution.
  - `signature` clears to 0.
  - Vector counter `cnt` clears to 0.
- Operand LFSR update, 16-bit Galois, right shift: `next = (s >> 1) ^ (s[0] ? 16'hB400 : 0)`.
- Control bits decode from `cnt`:
  - `alu_op = cnt[2:0]`
  - `alu_invA = cnt[3]`
  - `alu_invB = cnt[4]`
  - `alu_cin = cnt[5]`
  - `alu_sign = cnt[6]`
  - This walks all 8 ops under every inversion, carry and sign combination within 128 vectors.
- MISR update, each RUN edge:
  - Data word `d = alu_out ^ {14'b0, alu_ofl, alu_zero}`.
  - `sig_next = ({sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 0)) ^ d`.
  - On the same edge, both operand LFSRs advance and `cnt` increments.
- Last vector: when `cnt == N_VECTORS-1` on a RUN edge, the MISR absorbs it and the FSM moves to DONE. `cnt` does not wrap.
- DONE holds `signature`, `pass` and the last ALU drive values until `start` or `rst`.
- `pass` is registered: it is computed from `sig_next` on the edge entering DONE and cleared on run entry.

## Timing
- Reset values: every output is 0 (`busy`, `done`, `pass`, `signature`, `alu_a`, `alu_b`, `alu_op`, `alu_cin`, `alu_invA`, `alu_invB`, `alu_sign`). State is IDLE and `cnt` is 0.
- The ALU is combinational. A vector is driven from registers for one full cycle, and its response is absorbed on the following edge.
- Start edge t0: `busy` = 1, vector 0 is driven.
- Edge t(i+1): vector i is absorbed and vector i+1 is driven.
- Edge tN: `busy` = 0, `done` = 1, `pass` is valid. `done` therefore rises exactly `N_VECTORS` cycles after the start edge.
- Restart from DONE: `done` and `pass` drop on the start edge, and `busy` rises on that same edge.
- `rst` mid-run: on the next edge, state IDLE and all outputs 0. A following run reproduces an identical signature.
- `rst` and `start` asserted together: `rst` wins.

## Structure
- Shared include file `alu_bist_defs.v`:
  - ALU op encodings: ROL=0, SLL=1, ROR=2, SRA=3, ADD=4, OR=5, XOR=6, AND=7.
  - `LFSR_POLY` = 16'hB400.
  - `MISR_POLY` = 16'h1021.
  - State encodings for IDLE, RUN, DONE.
- Sub-module `bist_lfsr16`: 16-bit Galois LFSR with parameterised polynomial and ports `clk`, `rst`, `load`, `seed`, `en`, `state`. It is instantiated twice, once for operand A and once for operand B.
- The MISR and FSM stay in `alu_bist`. The MISR is not a `bist_lfsr16` instance because it shifts left and XORs in data.

## Test plan
- Reset: hold `rst` for 2 cycles with `start` = 1 → all outputs 0 and state IDLE; `start` has no effect.
- Sequence (`N_VECTORS` = 8), one-cycle `start` pulse:
  - On the start edge: `alu_a` = 16'hACE1, `alu_b` = 16'h1D2B, `alu_op` = 0, `busy` = 1.
  - Next edge: `alu_a` = 16'hE270, `alu_op` = 1.
  - `done` rises exactly 8 cycles after the start edge; `busy` falls on the same edge.
- Signature: bind the real ALU and set `GOLDEN_SIG` from the bench model (`N_VECTORS` = 256) → `pass` = 1. Force `alu_out[0]` stuck-at-0 → `pass` = 0 and `signature` ≠ `GOLDEN_SIG`.
- Reset mid-run: assert `rst` at vector 3 → all outputs 0 the next cycle. Rerun → same final signature as an uninterrupted run.
- Handshake:
  - Hold `start` high throughout RUN → no restart, `done` still rises at cycle N.
  - Pulse `start` in DONE → `done` and `pass` clear and `alu_a` reloads 16'hACE1 on that edge.
- Zero seed: with `SEED_A` = 0 → first vector `alu_a` = 16'h0001, second vector `alu_a` = 16'hB400.
